cart_ram_bk_sequencer: RTL and testbench

Sequences and arbitrates the cartridge RAM port between two requesters. One is the Game Boy side (the cart RAM read/write strobes produced by the memory bank controller). The other is a battery-backup engine that streams the whole save RAM image to or from the host, in 512-byte sectors.
Sits between the MBC's ram_addr/ram_rd/ram_wr/ram_di/ram_do and the single-port synchronous cart RAM.

---
 rtl/cart_ram_bk_sequencer_if.sv | 44 ++++
 rtl/cart_ram_bk_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cart_ram_bk_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_ram_bk_sequencer_if.sv
// Cart RAM sequencer bus: Game Boy port, cart RAM port and battery-backup stream.
// The sequencer takes the slave modport; the requesters and the RAM take master.
interface cart_ram_bk_sequencer_if #(
    parameter int AW        = 17,
    parameter int SECT_BITS = 9
);
    logic [AW-1:0]           gb_addr;
    logic                    gb_rd;
    logic                    gb_wr;
    logic [7:0]              gb_di;
    logic [7:0]              gb_do;

    logic [AW-1:0]           mem_addr;
    logic                    mem_we;
    logic [7:0]              mem_di;
    logic [7:0]              mem_do;

    logic                    bk_load;
    logic                    bk_save;
    logic [7:0]              bk_din;
    logic                    bk_din_valid;
    logic                    bk_din_ready;
    logic [7:0]              bk_dout;
    logic                    bk_dout_valid;
    logic                    bk_dout_ready;
    logic [AW-SECT_BITS-1:0] bk_lba;
    logic                    bk_busy;
    logic                    bk_done;
    logic                    bk_dirty;

    modport slave (
        input  gb_addr, gb_rd, gb_wr, gb_di, mem_do,
               bk_load, bk_save, bk_din, bk_din_valid, bk_dout_ready,
        output gb_do, mem_addr, mem_we, mem_di,
               bk_din_ready, bk_dout, bk_dout_valid, bk_lba, bk_busy, bk_done, bk_dirty
    );

    modport master (
        output gb_addr, gb_rd, gb_wr, gb_di, mem_do,
               bk_load, bk_save, bk_din, bk_din_valid, bk_dout_ready,
        input  gb_do, mem_addr, mem_we, mem_di,
               bk_din_ready, bk_dout, bk_dout_valid, bk_lba, bk_busy, bk_done, bk_dirty
    );
endinterface

// File: rtl/cart_ram_bk_sequencer.sv
// Arbitrates the single-port cart RAM between the Game Boy (fixed priority) and a
// sector-streaming battery-backup engine. Optional BK_AUTOSAVE_EN: save on OSD open when dirty.
module cart_ram_bk_sequencer #(
    parameter int AW        = 17,
    parameter int SECT_BITS = 9
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    cart_mbc2,
    input  logic [7:0]              cart_ram_size,
    input  logic                    osd_open,
    cart_ram_bk_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        SV_RD,
        SV_CAP,
        SV_HOLD,
        FIN
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] counter, counter_n;
    logic [7:0]    dout_q, dout_n;
    logic          dirty_q;

    logic [8:0]    img_sectors;
    logic [AW:0]   img_bytes;
    logic [AW-1:0] last_idx;
    logic          img_empty;
    logic          is_last;
    logic          gb_access;
    logic          save_req;
    logic          autosave_req;
    logic          start_xfer;

    logic [AW-1:0] mem_addr_c;
    logic          mem_we_c;
    logic [7:0]    mem_di_c;
    logic          din_ready_c;
    logic          dout_valid_c;
    logic          busy_c;
    logic          done_c;

    always_comb begin
        img_sectors = 9'd0;
        if (cart_mbc2) begin
            img_sectors = 9'd1;
        end else begin
            case (cart_ram_size)
                8'd0:    img_sectors = 9'd0;
                8'd1:    img_sectors = 9'd4;
                8'd2:    img_sectors = 9'd16;
                8'd3:    img_sectors = 9'd64;
                default: img_sectors = 9'd256;
            endcase
        end
    end

    assign img_bytes = (AW+1)'(img_sectors) << SECT_BITS;
    assign last_idx  = AW'(img_bytes - (AW+1)'(1));
    assign img_empty = (img_sectors == 9'd0);
    assign is_last   = (counter == last_idx);
    assign gb_access = bus.gb_rd | bus.gb_wr;

`ifdef BK_AUTOSAVE_EN
    logic osd_q;

    always_ff @(posedge clk_sys) begin
        if (reset) osd_q <= 1'b0;
        else       osd_q <= osd_open;
    end

    assign autosave_req = osd_open & ~osd_q & dirty_q & ~img_empty;
`else
    logic unused_osd_open;
    assign unused_osd_open = osd_open;
    assign autosave_req    = 1'b0;
`endif

    assign save_req = bus.bk_save | autosave_req;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            dout_q  <= 8'd0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            dout_q  <= dout_n;
        end
    end

    // A Game Boy write in the same cycle as a transfer start leaves the image dirty.
    always_ff @(posedge clk_sys) begin
        if (reset)           dirty_q <= 1'b0;
        else if (bus.gb_wr)  dirty_q <= 1'b1;
        else if (start_xfer) dirty_q <= 1'b0;
    end

    always_comb begin
        state_n      = state;
        counter_n    = counter;
        dout_n       = dout_q;
        start_xfer   = 1'b0;
        mem_addr_c   = '0;
        mem_we_c     = 1'b0;
        mem_di_c     = 8'd0;
        din_ready_c  = 1'b0;
        dout_valid_c = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;

        if (gb_access) begin
            mem_addr_c = bus.gb_addr;
            mem_we_c   = bus.gb_wr;
            mem_di_c   = bus.gb_di;
        end

        case (state)
            IDLE: begin
                if (bus.bk_load || save_req) begin
                    start_xfer = 1'b1;
                    if (img_empty) begin
                        state_n = FIN;
                    end else begin
                        counter_n = '0;
                        state_n   = bus.bk_load ? LD_WAIT : SV_RD;
                    end
                end
            end
            LD_WAIT: begin
                busy_c = 1'b1;
                if (bus.bk_din_valid && !gb_access) begin
                    din_ready_c = 1'b1;
                    mem_addr_c  = counter;
                    mem_we_c    = 1'b1;
                    mem_di_c    = bus.bk_din;
                    if (is_last) state_n = FIN;
                    else         counter_n = counter + AW'(1);
                end
            end
            SV_RD: begin
                busy_c = 1'b1;
                if (!gb_access) begin
                    mem_addr_c = counter;
                    state_n    = SV_CAP;
                end
            end
            // Read data belongs to the engine's address even if the Game Boy now owns the port.
            SV_CAP: begin
                busy_c  = 1'b1;
                dout_n  = bus.mem_do;
                state_n = SV_HOLD;
            end
            SV_HOLD: begin
                busy_c       = 1'b1;
                dout_valid_c = 1'b1;
                if (bus.bk_dout_ready) begin
                    if (is_last) begin
                        state_n = FIN;
                    end else begin
                        counter_n = counter + AW'(1);
                        state_n   = SV_RD;
                    end
                end
            end
            FIN: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.gb_do         = bus.mem_do;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_di        = mem_di_c;
    assign bus.bk_din_ready  = din_ready_c;
    assign bus.bk_dout       = dout_q;
    assign bus.bk_dout_valid = dout_valid_c;
    assign bus.bk_lba        = counter[AW-1:SECT_BITS];
    assign bus.bk_busy       = busy_c;
    assign bus.bk_done       = done_c;
    assign bus.bk_dirty      = dirty_q;

endmodule

// File: tb/tb_cart_ram_bk_sequencer.sv
// Directed bench for cart_ram_bk_sequencer with a behavioural single-port cart RAM.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_cart_ram_bk_sequencer;

    localparam int AW        = 17;
    localparam int RAM_BYTES = 1 << AW;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       cart_mbc2;
    logic [7:0] cart_ram_size;
    logic       osd_open;

    int n_compared   = 0;
    int n_mismatched = 0;

    cart_ram_bk_sequencer_if #(.AW(AW), .SECT_BITS(9)) bus ();

    cart_ram_bk_sequencer #(.AW(AW), .SECT_BITS(9)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .cart_mbc2     (cart_mbc2),
        .cart_ram_size (cart_ram_size),
        .osd_open      (osd_open),
        .bus           (bus)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'((i * 7 + seed) ^ (i >> 8));
    endfunction

    function automatic logic [7:0] lpat(input int i, input bit invert);
        return invert ? ~8'(i) : 8'(i);
    endfunction

    // Cart RAM model; the preload port fills the whole array in one edge.
    logic [7:0] ram [0:RAM_BYTES-1];
    logic [7:0] mem_do_r;
    logic       preload_req = 1'b0;
    int         preload_seed = 0;

    always @(posedge clk_sys) begin
        if (preload_req) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= pat(i, preload_seed);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_di;
        end
        mem_do_r <= ram[bus.mem_addr];
    end

    assign bus.mem_do = mem_do_r;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk_sys);
    endtask

    task automatic idleInputs();
        bus.gb_addr       = '0;
        bus.gb_rd         = 1'b0;
        bus.gb_wr         = 1'b0;
        bus.gb_di         = 8'd0;
        bus.bk_load       = 1'b0;
        bus.bk_save       = 1'b0;
        bus.bk_din        = 8'd0;
        bus.bk_din_valid  = 1'b0;
        bus.bk_dout_ready = 1'b0;
    endtask

    task automatic doPreload(input int seed);
        applyStimulus();
        preload_seed = seed;
        preload_req  = 1'b1;
        applyStimulus();
        preload_req  = 1'b0;
    endtask

    task automatic gbWrite(input logic [AW-1:0] addr, input logic [7:0] data);
        applyStimulus();
        bus.gb_addr = addr;
        bus.gb_di   = data;
        bus.gb_wr   = 1'b1;
        applyStimulus();
        bus.gb_wr   = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"},       32'(bus.bk_busy),       32'd0);
        checkOutput({tag, " dout_valid"}, 32'(bus.bk_dout_valid), 32'd0);
        checkOutput({tag, " done"},       32'(bus.bk_done),       32'd0);
        checkOutput({tag, " din_ready"},  32'(bus.bk_din_ready),  32'd0);
        checkOutput({tag, " lba"},        32'(bus.bk_lba),        32'd0);
        checkOutput({tag, " dout"},       32'(bus.bk_dout),       32'd0);
        checkOutput({tag, " dirty"},      32'(bus.bk_dirty),      32'd0);
        checkOutput({tag, " mem_we"},     32'(bus.mem_we),        32'd0);
        checkOutput({tag, " mem_addr"},   32'(bus.mem_addr),      32'd0);
    endtask

    // Starts a save and streams it; abort_at >= 0 returns once that many bytes have been taken.
    task automatic runSave(input string tag, input int nbytes, input int seed,
                           input bit noisy, input int abort_at);
        int rx = 0, done_cnt = 0, byte_err = 0, lba_err = 0, busy_err = 0;
        int we_err = 0, gb_err = 0, gb_cnt = 0;
        logic          prev_rd = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        applyStimulus();
        bus.bk_save = 1'b1;
        applyStimulus();
        bus.bk_save = 1'b0;
        for (int cyc = 0; cyc < nbytes * 12 + 100; cyc++) begin
            bus.bk_dout_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.gb_rd         = noisy && (cyc % 2 == 1);
            bus.gb_addr       = AW'($urandom_range(0, RAM_BYTES - 1));
            #1;
            if (prev_rd) begin
                gb_cnt++;
                if (bus.gb_do !== pat(int'(prev_addr), seed)) gb_err++;
            end
            prev_rd   = bus.gb_rd;
            prev_addr = bus.gb_addr;
            if (bus.mem_we) we_err++;
            if (bus.bk_dout_valid && bus.bk_dout_ready) begin
                if (bus.bk_dout !== pat(rx, seed)) byte_err++;
                if (32'(bus.bk_lba) != 32'(rx >> 9)) lba_err++;
                rx++;
            end
            if (bus.bk_done) begin
                done_cnt++;
                if (bus.bk_busy) busy_err++;
            end else if (!bus.bk_busy) begin
                busy_err++;
            end
            if (abort_at >= 0 && rx == abort_at) break;
            if (done_cnt > 0) break;
            applyStimulus();
        end
        bus.gb_rd = 1'b0;
        if (abort_at >= 0) begin
            checkOutput({tag, " bytes before abort"}, 32'(rx), 32'(abort_at));
            checkOutput({tag, " bad bytes"}, 32'(byte_err), 32'd0);
            return;
        end
        applyStimulus();
        bus.bk_dout_ready = 1'b0;
        #1;
        if (bus.bk_done) done_cnt++;
        checkOutput({tag, " bytes"},       32'(rx),       32'(nbytes));
        checkOutput({tag, " bad bytes"},   32'(byte_err), 32'd0);
        checkOutput({tag, " bad lba"},     32'(lba_err),  32'd0);
        checkOutput({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, " busy errors"}, 32'(busy_err), 32'd0);
        checkOutput({tag, " mem writes"},  32'(we_err),   32'd0);
        checkOutput({tag, " busy after"},  32'(bus.bk_busy), 32'd0);
        if (noisy) begin
            checkOutput({tag, " gb read errors"}, 32'(gb_err), 32'd0);
            checkOutput({tag, " gb reads seen"},  32'(gb_cnt > 100), 32'd1);
        end
    endtask

    task automatic runLoad(input string tag, input int nbytes, input bit invert,
                           input bit with_save, input bit mid_save);
        int tx = 0, done_cnt = 0, valid_err = 0, busy_err = 0, ram_err = 0, idle_err = 0;
        bit save_sent = 1'b0;
        applyStimulus();
        bus.bk_load = 1'b1;
        bus.bk_save = with_save;
        applyStimulus();
        bus.bk_load = 1'b0;
        bus.bk_save = 1'b0;
        for (int cyc = 0; cyc < nbytes * 4 + 100; cyc++) begin
            bus.bk_din       = lpat(tx, invert);
            bus.bk_din_valid = invert ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.bk_save      = 1'b0;
            if (mid_save && tx == 100 && !save_sent) begin
                bus.bk_save = 1'b1;
                save_sent   = 1'b1;
            end
            #1;
            if (bus.bk_din_ready) tx++;
            if (bus.bk_dout_valid) valid_err++;
            if (bus.bk_done) begin
                done_cnt++;
                break;
            end else if (!bus.bk_busy) begin
                busy_err++;
            end
            applyStimulus();
        end
        for (int i = 0; i < nbytes; i++) if (ram[i] !== lpat(i, invert)) ram_err++;
        applyStimulus();
        bus.bk_din_valid = 1'b0;
        bus.bk_save      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.bk_busy || bus.bk_done || bus.bk_dout_valid) idle_err++;
            applyStimulus();
        end
        checkOutput({tag, " ready pulses"},  32'(tx),        32'(nbytes));
        checkOutput({tag, " done pulses"},   32'(done_cnt),  32'd1);
        checkOutput({tag, " dout_valid"},    32'(valid_err), 32'd0);
        checkOutput({tag, " busy errors"},   32'(busy_err),  32'd0);
        checkOutput({tag, " ram errors"},    32'(ram_err),   32'd0);
        checkOutput({tag, " idle after"},    32'(idle_err),  32'd0);
    endtask

    initial begin
        int zdone, zbad, hits;
        reset         = 1'b1;
        cart_mbc2     = 1'b0;
        cart_ram_size = 8'd0;
        osd_open      = 1'b0;
        idleInputs();
        repeat (3) applyStimulus();
        #1;
        checkAllZero("reset");
        applyStimulus();
        reset = 1'b0;

        // Game Boy access owns the port and marks the image dirty
        applyStimulus();
        bus.gb_addr = 17'h1_2345;
        bus.gb_di   = 8'hA5;
        bus.gb_wr   = 1'b1;
        #1;
        checkOutput("gb mem_addr", 32'(bus.mem_addr), 32'h1_2345);
        checkOutput("gb mem_we",   32'(bus.mem_we),   32'd1);
        checkOutput("gb mem_di",   32'(bus.mem_di),   32'hA5);
        applyStimulus();
        bus.gb_wr = 1'b0;
        #1;
        checkOutput("dirty after gb_wr", 32'(bus.bk_dirty), 32'd1);

        doPreload(3);
        cart_ram_size = 8'd2;
        runSave("save16", 8192, 3, 1'b0, -1);
        checkOutput("dirty after save", 32'(bus.bk_dirty), 32'd0);

        cart_mbc2 = 1'b1;
        gbWrite(17'h1_FFFF, 8'h5A);
        runLoad("load mbc2", 512, 1'b0, 1'b0, 1'b0);
        checkOutput("dirty after load", 32'(bus.bk_dirty), 32'd0);

        cart_mbc2     = 1'b0;
        cart_ram_size = 8'd1;
        doPreload(11);
        runSave("save noisy", 2048, 11, 1'b1, -1);

        cart_mbc2 = 1'b1;
        runLoad("load+save", 512, 1'b1, 1'b1, 1'b1);

        // Empty image: request finishes without touching RAM
        cart_mbc2     = 1'b0;
        cart_ram_size = 8'd0;
        zdone = 0;
        zbad  = 0;
        applyStimulus();
        bus.bk_save = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.bk_done) zdone++;
            if (bus.mem_we || bus.bk_dout_valid || bus.bk_busy) zbad++;
            applyStimulus();
            bus.bk_save = 1'b0;
        end
        checkOutput("empty done pulses", 32'(zdone), 32'd1);
        checkOutput("empty activity",    32'(zbad),  32'd0);

        // Reset in the middle of a save, then a clean restart from byte 0
        cart_ram_size = 8'd1;
        doPreload(21);
        runSave("save abort", 2048, 21, 1'b0, 1000);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        #1;
        checkAllZero("mid reset");
        applyStimulus();
        reset             = 1'b0;
        bus.bk_dout_ready = 1'b0;
        runSave("save restart", 2048, 21, 1'b0, -1);

        // OSD open edge with a dirty image
        cart_mbc2 = 1'b1;
        gbWrite(17'h1_FF00, 8'h33);
        applyStimulus();
        osd_open = 1'b1;
        applyStimulus();
        #1;
`ifdef BK_AUTOSAVE_EN
        checkOutput("autosave busy", 32'(bus.bk_busy), 32'd1);
        bus.bk_dout_ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 3000 && hits == 0; i++) begin
            applyStimulus();
            #1;
            if (bus.bk_done) hits++;
        end
        bus.bk_dout_ready = 1'b0;
        checkOutput("autosave done", 32'(hits), 32'd1);
        checkOutput("autosave dirty", 32'(bus.bk_dirty), 32'd0);
        applyStimulus();
        osd_open = 1'b0;
        applyStimulus();
        osd_open = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            #1;
            if (bus.bk_busy) hits++;
        end
        checkOutput("clean osd edge busy", 32'(hits), 32'd0);
`else
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.bk_busy) hits++;
            applyStimulus();
            #1;
        end
        checkOutput("osd ignored busy", 32'(hits), 32'd0);
        checkOutput("osd ignored dirty", 32'(bus.bk_dirty), 32'd1);
`endif
        osd_open = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
